// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the 4-port packet scheduler:
//   NPORTS        - number of input ports feeding the shared output
//   DATA_W_DEF    - default beat width
//   state_e       - scheduler FSM states (IDLE, WAIT, XFER)
//   sel_hit()     - one-hot select test against a per-port vector
// ---------------------------------------------------------------------------
package sched_pkg;

  localparam int NPORTS     = 4;
  localparam int DATA_W_DEF = 134;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_e;

  // True when the port picked by a one-hot select has its bit set in vec.
  function automatic logic sel_hit(input logic [NPORTS-1:0] sel,
                                   input logic [NPORTS-1:0] vec);
    return |(sel & vec);
  endfunction

endpackage

// File: rtl/sched_out_reg.sv
// ---------------------------------------------------------------------------
// sched_out_reg
// Single-entry output pipeline register with valid/ready handshake.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   load                 - capture load_data/load_eop this cycle
//   load_data, load_eop  - beat to capture
//   load_ok              - register can take a beat this cycle
//   out_valid/data/eop   - registered output beat
//   out_ready            - downstream accept
// ---------------------------------------------------------------------------
module sched_out_reg #(
  parameter int DATA_W = 134
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_eop,
  output logic              load_ok,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eop,
  input  logic              out_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              eop_q, eop_d;

  // Space exists when empty or when the held beat leaves this cycle.
  assign load_ok = ~valid_q | out_ready;

  // Next-state of the output register: load wins, otherwise drain on ready.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    eop_d   = eop_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      eop_d   = load_eop;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register state; data/eop are held while valid and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      eop_q   <= eop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_eop   = eop_q;

endmodule

// File: rtl/pkt_sched_4to1.sv
// ---------------------------------------------------------------------------
// pkt_sched_4to1
// Consumer side of a 4-port round-robin grant handshake. Pending packets are
// advertised on req_bits, a registered one-hot grant is confirmed with a
// single-cycle get pulse, and the granted port's packet is forwarded beat by
// beat through a one-stage output register until end-of-packet.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/data/eop     - per-port beat inputs (port p at [p*DATA_W +: DATA_W])
//   in_ready              - per-port beat accept
//   req_bits, grant_bits  - arbiter request out / registered one-hot grant in
//   get                   - one-cycle pulse, grant consumed
//   out_valid/data/eop    - registered output beat
//   out_ready             - downstream accept
//   pkt_cnt               - forwarded packet count, wraps
// ---------------------------------------------------------------------------
module pkt_sched_4to1
  import sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS-1:0]        in_eop,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS-1:0]        req_bits,
  input  logic [NPORTS-1:0]        grant_bits,
  output logic                     get,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_eop,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         pkt_cnt
);

  state_e            state_q, state_d;
  logic [NPORTS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [DATA_W-1:0] mux_data;
  logic              mux_eop;
  logic              mux_valid;
  logic              load_ok;
  logic              beat_acc;
  logic [NPORTS-1:0] req_s;
  logic [NPORTS-1:0] in_ready_s;
  logic              get_s;

  // One-hot AND-OR mux of the selected port's beat; sel_q = 0 yields zeros.
  always_comb begin
    mux_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      mux_data = mux_data | (in_data[p*DATA_W +: DATA_W] & {DATA_W{sel_q[p]}});
    end
  end

  assign mux_eop   = sel_hit(sel_q, in_eop);
  assign mux_valid = sel_hit(sel_q, in_valid);

  // Scheduler FSM next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pkt_cnt_d  = pkt_cnt_q;
    req_s      = '0;
    in_ready_s = '0;
    get_s      = 1'b0;
    beat_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        req_s = in_valid;
        if (in_valid != '0) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        req_s = in_valid;
        // A grant only counts if its port still has a packet pending.
        if ((grant_bits & in_valid) != '0) begin
          get_s   = 1'b1;
          sel_d   = grant_bits;
          state_d = XFER;
        end else if (in_valid == '0) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      XFER: begin
        in_ready_s = sel_q & {NPORTS{load_ok}};
        beat_acc   = mux_valid & load_ok;
        if (beat_acc && mux_eop) begin
          state_d   = IDLE;
          sel_d     = '0;
          pkt_cnt_d = pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // FSM state, port select and packet counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  sched_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (beat_acc),
    .load_data (mux_data),
    .load_eop  (mux_eop),
    .load_ok   (load_ok),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_ready (out_ready)
  );

  // req_bits follows in_valid combinationally in IDLE, so it is masked with
  // rst_n to present zero to the arbiter while reset is held.
  assign req_bits = req_s & {NPORTS{rst_n}};
  assign in_ready = in_ready_s;
  assign get      = get_s;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_sched_4to1.sv
// ---------------------------------------------------------------------------
// tb_pkt_sched_4to1
// Directed bench for pkt_sched_4to1 (CNT_W = 4) with a behavioural
// round-robin arbiter returning a registered one-hot grant.
// ---------------------------------------------------------------------------
module tb_pkt_sched_4to1;

  localparam int DATA_W = 134;
  localparam int CNT_W  = 4;

  logic                clk;
  logic                rst_n;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_eop;
  logic [3:0]          in_ready;
  logic [3:0]          req_bits;
  logic [3:0]          grant_bits;
  logic                get;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_eop;
  logic                out_ready;
  logic [CNT_W-1:0]    pkt_cnt;

  int vectors;
  int miscompares;

  // port source state
  int rem [4];
  int bidx[4];
  int tag [4];

  // sampled outputs of the most recent cycle
  logic [3:0]        s_req, s_in_ready;
  logic              s_get, s_ov, s_oe;
  logic [DATA_W-1:0] s_od;
  logic [CNT_W-1:0]  s_cnt;
  int                get_cnt;

  // captured output beats
  logic [DATA_W-1:0] cap_data[32];
  logic              cap_eop [32];
  int                cap_n;

  // arbiter model
  logic       use_arb;
  logic [3:0] man_grant;
  logic [3:0] arb_grant;
  logic [1:0] arb_last;

  pkt_sched_4to1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_eop(in_eop), .in_ready(in_ready), .req_bits(req_bits),
    .grant_bits(grant_bits), .get(get), .out_valid(out_valid),
    .out_data(out_data), .out_eop(out_eop), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [3:0] g;
    int idx;
    g = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last) + k) % 4;
      if (g == 4'b0000 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] e;
    e = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) e = 2'(k);
    return e;
  endfunction

  // Round-robin arbiter: registered grant, cleared when consumed by get.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= 4'b0000;
      arb_last  <= 2'd3;
    end else if (get) begin
      arb_grant <= 4'b0000;
      arb_last  <= enc(arb_grant);
    end else if (arb_grant == 4'b0000) begin
      arb_grant <= rr_pick(req_bits, arb_last);
    end
  end

  assign grant_bits = use_arb ? arb_grant : man_grant;

  function automatic logic [DATA_W-1:0] mk(input int p, input int t, input int b);
    logic [DATA_W-1:0] d;
    d = '0;
    d[7:0]   = b[7:0];
    d[15:8]  = t[7:0];
    d[23:16] = p[7:0];
    d[DATA_W-1 -: 8] = 8'hA5 ^ p[7:0];
    return d;
  endfunction

  task automatic drive_ports();
    for (int p = 0; p < 4; p++) begin
      in_valid[p] = (rem[p] > 0);
      in_eop[p]   = (rem[p] == 1);
      in_data[p*DATA_W +: DATA_W] = (rem[p] > 0) ? mk(p, tag[p], bidx[p]) : '0;
    end
  endtask

  task automatic start_pkt(input int p, input int len, input int t);
    rem[p] = len; bidx[p] = 0; tag[p] = t;
    drive_ports();
  endtask

  task automatic clear_cap();
    cap_n = 0; get_cnt = 0;
  endtask

  // Sample one cycle at negedge, then advance sources after the posedge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    s_req = req_bits; s_get = get; s_in_ready = in_ready;
    s_ov = out_valid; s_od = out_data; s_oe = out_eop; s_cnt = pkt_cnt;
    acc = in_valid & in_ready;
    if (get) get_cnt++;
    if (out_valid && out_ready && cap_n < 32) begin
      cap_data[cap_n] = out_data;
      cap_eop[cap_n]  = out_eop;
      cap_n++;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (acc[p]) begin rem[p]--; bidx[p]++; end
    end
    drive_ports();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b1; use_arb = 1'b1; man_grant = 4'b0000;
    for (int p = 0; p < 4; p++) begin rem[p] = 0; bidx[p] = 0; tag[p] = 0; end
    drive_ports();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) rem[p] = 1;
    drive_ports();
    clear_cap();
    step();
    vectors++; if (s_req !== 4'b0000) begin miscompares++; $display("FAIL rst_req: got %b expected 0000", s_req); end
    vectors++; if (s_in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0000", s_in_ready); end
    vectors++; if ({s_get, s_ov, s_oe} !== 3'b000) begin miscompares++; $display("FAIL rst_ctl: got get/ov/eop=%b expected 000", {s_get, s_ov, s_oe}); end
    vectors++; if (s_od !== '0) begin miscompares++; $display("FAIL rst_data: got %h expected 0", s_od); end
    vectors++; if (s_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d expected 0", s_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    logic [6:0] ov_tr, get_tr, eop_tr;
    logic [3:0] req0;
    do_reset(); clear_cap();
    req0 = 4'b0000;
    start_pkt(2, 3, 8'h11);
    for (int i = 0; i < 7; i++) begin
      step();
      ov_tr[i] = s_ov; get_tr[i] = s_get; eop_tr[i] = s_ov & s_oe;
      if (i == 0) req0 = s_req;
    end
    vectors++; if (req0 !== 4'b0100) begin miscompares++; $display("FAIL single_req: got %b expected 0100", req0); end
    vectors++; if (get_tr !== 7'b0000010) begin miscompares++; $display("FAIL single_get: got %b expected 0000010", get_tr); end
    vectors++; if (ov_tr !== 7'b0111000) begin miscompares++; $display("FAIL single_ov: got %b expected 0111000", ov_tr); end
    vectors++; if (eop_tr !== 7'b0100000) begin miscompares++; $display("FAIL single_eop: got %b expected 0100000", eop_tr); end
    vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL single_cnt: got %0d expected 1", pkt_cnt); end
    vectors++; if (cap_n !== 3) begin miscompares++; $display("FAIL single_beats: got %0d expected 3", cap_n); end
    for (int b = 0; b < 3 && b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== mk(2, 8'h11, b) || cap_eop[b] !== (b == 2)) begin
        miscompares++; $display("FAIL single_beat%0d: got %h/%b expected %h/%b", b, cap_data[b], cap_eop[b], mk(2, 8'h11, b), (b == 2));
      end
    end
  endtask

  task automatic test_two_ports();
    do_reset(); clear_cap();
    start_pkt(0, 1, 8'h20);
    start_pkt(3, 1, 8'h23);
    repeat (10) step();
    vectors++; if (get_cnt !== 2) begin miscompares++; $display("FAIL rr_gets: got %0d expected 2", get_cnt); end
    vectors++; if (pkt_cnt !== 4'd2) begin miscompares++; $display("FAIL rr_cnt: got %0d expected 2", pkt_cnt); end
    vectors++; if (cap_n !== 2) begin miscompares++; $display("FAIL rr_beats: got %0d expected 2", cap_n); end
    vectors++; if (cap_data[0] !== mk(0, 8'h20, 0) || cap_eop[0] !== 1'b1) begin miscompares++; $display("FAIL rr_first: got %h expected %h", cap_data[0], mk(0, 8'h20, 0)); end
    vectors++; if (cap_data[1] !== mk(3, 8'h23, 0) || cap_eop[1] !== 1'b1) begin miscompares++; $display("FAIL rr_second: got %h expected %h", cap_data[1], mk(3, 8'h23, 0)); end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_cap();
    start_pkt(1, 4, 8'h31);
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 4 && i <= 8);
      step();
      if (i >= 4 && i <= 8) begin
        vectors++;
        if (s_od !== mk(1, 8'h31, 1) || s_ov !== 1'b1) begin
          miscompares++; $display("FAIL bp_hold%0d: got %h/%b expected %h/1", i, s_od, s_ov, mk(1, 8'h31, 1));
        end
        vectors++;
        if (s_in_ready !== 4'b0000) begin
          miscompares++; $display("FAIL bp_ready%0d: got %b expected 0000", i, s_in_ready);
        end
      end
    end
    out_ready = 1'b1;
    vectors++; if (cap_n !== 4) begin miscompares++; $display("FAIL bp_beats: got %0d expected 4", cap_n); end
    for (int b = 0; b < 4 && b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== mk(1, 8'h31, b)) begin
        miscompares++; $display("FAIL bp_beat%0d: got %h expected %h", b, cap_data[b], mk(1, 8'h31, b));
      end
    end
    vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL bp_cnt: got %0d expected 1", pkt_cnt); end
  endtask

  task automatic test_withdraw();
    do_reset(); clear_cap();
    use_arb = 1'b0; man_grant = 4'b0000;
    start_pkt(1, 1, 8'h41);
    step();
    vectors++; if (s_req !== 4'b0010) begin miscompares++; $display("FAIL wd_req0: got %b expected 0010", s_req); end
    rem[1] = 0; drive_ports(); man_grant = 4'b0010;
    step();
    vectors++; if (s_get !== 1'b0) begin miscompares++; $display("FAIL wd_get: got %b expected 0", s_get); end
    vectors++; if (s_req !== 4'b0000) begin miscompares++; $display("FAIL wd_req1: got %b expected 0000", s_req); end
    // with the grant still held, a new request must first pass through IDLE
    start_pkt(1, 1, 8'h42);
    step();
    vectors++; if (s_get !== 1'b0 || s_req !== 4'b0010) begin miscompares++; $display("FAIL wd_idle: got get=%b req=%b expected get=0 req=0010", s_get, s_req); end
    step();
    vectors++; if (s_get !== 1'b1) begin miscompares++; $display("FAIL wd_get2: got %b expected 1", s_get); end
    repeat (4) step();
    man_grant = 4'b0000; use_arb = 1'b1;
    vectors++; if (cap_n !== 1 || cap_data[0] !== mk(1, 8'h42, 0)) begin miscompares++; $display("FAIL wd_beat: got n=%0d %h expected n=1 %h", cap_n, cap_data[0], mk(1, 8'h42, 0)); end
    vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL wd_cnt: got %0d expected 1", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_cap();
    vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL rm_pre_cnt: got %0d expected 1", pkt_cnt); end
    start_pkt(0, 4, 8'h51);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    vectors++; if ({s_ov, s_oe, s_get} !== 3'b000) begin miscompares++; $display("FAIL rm_ctl: got ov/eop/get=%b expected 000", {s_ov, s_oe, s_get}); end
    vectors++; if (s_od !== '0) begin miscompares++; $display("FAIL rm_data: got %h expected 0", s_od); end
    vectors++; if (s_in_ready !== 4'b0000 || s_req !== 4'b0000) begin miscompares++; $display("FAIL rm_hs: got ready=%b req=%b expected 0000/0000", s_in_ready, s_req); end
    vectors++; if (s_cnt !== 4'd0) begin miscompares++; $display("FAIL rm_cnt: got %0d expected 0", s_cnt); end
    rem[0] = 0; drive_ports();
    rst_n = 1'b1;
    start_pkt(0, 2, 8'h52);
    repeat (7) step();
    vectors++; if (cap_n !== 2) begin miscompares++; $display("FAIL rm_beats: got %0d expected 2", cap_n); end
    vectors++; if (cap_data[0] !== mk(0, 8'h52, 0) || cap_data[1] !== mk(0, 8'h52, 1)) begin miscompares++; $display("FAIL rm_data_after: got %h %h", cap_data[0], cap_data[1]); end
    vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL rm_cnt_after: got %0d expected 1", pkt_cnt); end
  endtask

  task automatic test_wrap();
    do_reset(); clear_cap();
    for (int k = 0; k < 17; k++) begin
      start_pkt(k % 4, 1, k);
      repeat (5) step();
      if (k == 14) begin
        vectors++; if (pkt_cnt !== 4'd15) begin miscompares++; $display("FAIL wrap_15: got %0d expected 15", pkt_cnt); end
      end else if (k == 15) begin
        vectors++; if (pkt_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_0: got %0d expected 0", pkt_cnt); end
      end else if (k == 16) begin
        vectors++; if (pkt_cnt !== 4'd1) begin miscompares++; $display("FAIL wrap_1: got %0d expected 1", pkt_cnt); end
      end
    end
    vectors++; if (cap_n !== 17) begin miscompares++; $display("FAIL wrap_beats: got %0d expected 17", cap_n); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; out_ready = 1'b1; use_arb = 1'b1; man_grant = 4'b0000;
    in_valid = 4'b0000; in_eop = 4'b0000; in_data = '0;
    for (int p = 0; p < 4; p++) begin rem[p] = 0; bidx[p] = 0; tag[p] = 0; end
    clear_cap();
    test_reset();
    test_single();
    test_two_ports();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
